// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave giving burst read/write access to NUM_WR write registers and NUM_RO read-only inputs.
// Latency: a word commits SYNC_STAGES+1 clk after its last SCK rise. There is no backpressure: the SPI master paces every transfer.
module spi_reg_bank #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter int                NUM_WR      = 42,
  parameter int                NUM_RO      = 6,
  parameter logic [DATA_W-1:0] RST_VAL     = '0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SCK,
  input  logic                     CS,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [NUM_RO*DATA_W-1:0] regr_bus,
  output logic [NUM_WR*DATA_W-1:0] regwr_bus,
  output logic [NUM_WR-1:0]        wr_strobe,
  output logic                     busy,
  output logic                     addr_err
);

  localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TOTAL = NUM_WR + NUM_RO;
  localparam int CMD_W = 1 + ADDR_W;
  localparam int SH_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1);

  localparam logic [CNT_W-1:0]  CMD_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  DAT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W:0]   TOT_X    = (ADDR_W+1)'(TOTAL);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [SS:0]        r_sck_sh;
  logic [SS:0]        r_cs_sh;
  logic [SS-1:0]      r_mosi_sh;
  logic               r_live;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [SH_W-1:0]    r_shift_in;
  logic [DATA_W-1:0]  r_shift_out;
  logic               r_rw;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_miso;
  logic               r_addr_err;
  logic [NUM_WR-1:0]  r_wr_strobe;
  logic [DATA_W-1:0]  r_regwr [NUM_WR];

  logic               w_sck, w_cs, w_mosi;
  logic               w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic [SH_W-1:0]    w_sh;
  logic               w_cmd_rw;
  logic [ADDR_W-1:0]  w_cmd_addr;
  logic               w_addr_valid;
  logic [ADDR_W-1:0]  w_next_addr;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0]  w_rd_dat;
  logic               w_rd_inv;

  // Bit SS-1 is the synchronised level, bit SS the previous sample for edge detection.
  assign w_sck      = r_sck_sh[SS-1];
  assign w_cs       = r_cs_sh[SS-1];
  assign w_mosi     = r_mosi_sh[SS-1];
  assign w_sck_rise =  w_sck & ~r_sck_sh[SS];
  assign w_sck_fall = ~w_sck &  r_sck_sh[SS];
  assign w_cs_rise  =  w_cs  & ~r_cs_sh[SS];
  assign w_cs_fall  = ~w_cs  &  r_cs_sh[SS];

  assign w_sh       = {r_shift_in[SH_W-2:0], w_mosi};
  assign w_cmd_rw   = w_sh[ADDR_W];
  assign w_cmd_addr = w_sh[ADDR_W-1:0];

  // In-range addresses wrap at TOTAL; out-of-range ones roll over the full address space.
  assign w_addr_valid = ({1'b0, r_addr} < TOT_X);
  assign w_next_addr  = (w_addr_valid && (r_addr == LAST_A)) ? '0 : r_addr + 1'b1;
  assign w_rd_addr    = (r_state == S_CMD) ? w_cmd_addr : w_next_addr;

  always_comb begin
    w_rd_dat = '0;
    w_rd_inv = ({1'b0, w_rd_addr} >= TOT_X);
    for (int i = 0; i < NUM_WR; i++)
      if ({1'b0, w_rd_addr} == (ADDR_W+1)'(i)) w_rd_dat = r_regwr[i];
    for (int j = 0; j < NUM_RO; j++)
      if ({1'b0, w_rd_addr} == (ADDR_W+1)'(NUM_WR + j)) w_rd_dat = regr_bus[j*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_sh    <= '0;
      r_cs_sh     <= '0;
      r_mosi_sh   <= '0;
      r_live      <= 1'b0;
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_miso      <= 1'b0;
      r_addr_err  <= 1'b0;
      r_wr_strobe <= '0;
      for (int i = 0; i < NUM_WR; i++) r_regwr[i] <= RST_VAL;
    end else begin
      r_sck_sh    <= {r_sck_sh[SS-1:0], SCK};
      r_cs_sh     <= {r_cs_sh[SS-1:0], CS};
      r_mosi_sh   <= {r_mosi_sh[SS-2:0], MOSI};
      r_wr_strobe <= '0;
      // The CS chain resets low, so a transaction can only start after CS has been seen high.
      if (w_cs) r_live <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= S_CMD;
            r_bit_cnt <= '0;
          end
        end
        S_CMD: begin
          if (w_sck_rise) begin
            r_shift_in <= w_sh;
            if (r_bit_cnt == CMD_LAST) begin
              r_bit_cnt <= '0;
              r_rw      <= w_cmd_rw;
              r_addr    <= w_cmd_addr;
              r_state   <= S_DATA;
              if (!w_cmd_rw) begin
                r_shift_out <= w_rd_dat;
                if (w_rd_inv) r_addr_err <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_sck_rise) begin
            r_shift_in <= w_sh;
            if (r_bit_cnt == DAT_LAST) begin
              r_bit_cnt <= '0;
              r_addr    <= w_next_addr;
              if (r_rw) begin
                if (!w_addr_valid) r_addr_err <= 1'b1;
                for (int i = 0; i < NUM_WR; i++) begin
                  if ({1'b0, r_addr} == (ADDR_W+1)'(i)) begin
                    r_regwr[i]     <= w_sh[DATA_W-1:0];
                    r_wr_strobe[i] <= 1'b1;
                  end
                end
              end else begin
                r_shift_out <= w_rd_dat;
                if (w_rd_inv) r_addr_err <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          if (w_sck_fall && !r_rw) begin
            r_miso      <= r_shift_out[DATA_W-1];
            r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Placed last so a word completing in the same clk still commits above.
      if (w_cs_rise) begin
        r_state <= S_IDLE;
        r_miso  <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_WR; g++) begin : g_flat
    assign regwr_bus[g*DATA_W +: DATA_W] = r_regwr[g];
  end

  assign wr_strobe = r_wr_strobe;
  assign MISO      = r_miso;
  assign addr_err  = r_addr_err;
  assign busy      = ~w_cs & r_live;

endmodule
